// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions used by the ALU and its bench-side blocks.
//   ALU_WIDTH : default operand width
//   opcode_e  : ALU operation encoding
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_SLT  = 4'h8,
    OP_SLTU = 4'h9
  } opcode_e;

endpackage

// File: rtl/alu_tb_pkg.sv
// alu_tb_pkg: types shared by the ALU stimulus driver and its FIFO.
//   drv_state_e : driver FSM states
//   drv_req_t   : one queued request (operands, opcode, signedness)
package alu_tb_pkg;

  import alu_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    WAIT  = 2'd2
  } drv_state_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] operand_a;
    logic [ALU_WIDTH-1:0] operand_b;
    opcode_e              opcode;
    logic                 signed_op;
  } drv_req_t;

endpackage

// File: rtl/alu_stim_driver_if.sv
// alu_stim_driver_if: generator -> driver request handshake.
//   req_valid / req_ready            : valid/ready handshake
//   req_operand_a/b, req_opcode,
//   req_signed_op                    : request payload
// Modports: master = generator side, slave = driver side.
interface alu_stim_driver_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_operand_a;
  logic [WIDTH-1:0] req_operand_b;
  opcode_e          req_opcode;
  logic             req_signed_op;

  modport master (
    output req_valid, req_operand_a, req_operand_b, req_opcode, req_signed_op,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_opcode, req_signed_op,
    output req_ready
  );

endinterface

// File: rtl/alu_drv_fifo.sv
// alu_drv_fifo: synchronous request FIFO of drv_req_t.
//   clk, rst_n    : clock, async active-low reset (pointers only)
//   push_i/pop_i  : write/read strobes, ignored when full/empty
//   wdata_i       : entry to write
//   rdata_o       : head entry (valid when !empty_o)
//   full_o/empty_o: registered occupancy flags
//   empty_nxt_o   : emptiness after this cycle's push/pop
// Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
module alu_drv_fifo
  import alu_tb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  drv_req_t wdata_i,
  output drv_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     empty_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  drv_req_t    mem_q [DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o     = (wr_ptr_q == rd_ptr_q);
    do_push     = push_i && !full_o;
    do_pop      = pop_i && !empty_o;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(do_pop);
    empty_nxt_o = (wr_ptr_d == rd_ptr_d);
    rdata_o     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_stim_driver.sv
// alu_stim_driver: buffers ALU requests and applies them to the DUT one at a
// time, strobing transaction_valid when the DUT result is valid.
//   clk, rst_n          : clock, async active-low reset
//   req_if (slave)      : request handshake + payload from the generator
//   enable              : permits issuing new transactions (checked in IDLE)
//   mon_ready           : monitor can accept (checked in IDLE)
//   operand_a/b, opcode,
//   signed_op           : DUT inputs
//   transaction_valid   : one-cycle strobe, DUT result valid
//   busy                : FIFO non-empty or FSM active (registered)
//   issued_count        : completed transactions, wraps (registered)
// Build option ALU_DRV_HOLD_ZERO_EN: drive DUT inputs to zero while IDLE
// instead of holding the last transaction.
// WIDTH must equal alu_pkg::ALU_WIDTH, which sizes the queued request type.
module alu_stim_driver
  import alu_pkg::*;
  import alu_tb_pkg::*;
#(
  parameter int unsigned WIDTH       = ALU_WIDTH,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DUT_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_stim_driver_if.slave    req_if,
  input  logic                enable,
  input  logic                mon_ready,
  output logic [WIDTH-1:0]    operand_a,
  output logic [WIDTH-1:0]    operand_b,
  output opcode_e             opcode,
  output logic                signed_op,
  output logic                transaction_valid,
  output logic                busy,
  output logic [31:0]         issued_count
);

  localparam int unsigned CNT_W = (DUT_LATENCY < 2) ? 1 : $clog2(DUT_LATENCY + 1);

  drv_state_e         state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  drv_req_t           op_q;
  logic [31:0]        issued_count_q;
  logic               busy_q;
  logic               pop;
  logic               strobe;

  drv_req_t           push_data, head_data;
  logic               fifo_full, fifo_empty, fifo_empty_nxt;

  always_comb begin
    push_data           = '0;
    push_data.operand_a = ALU_WIDTH'(req_if.req_operand_a);
    push_data.operand_b = ALU_WIDTH'(req_if.req_operand_b);
    push_data.opcode    = req_if.req_opcode;
    push_data.signed_op = req_if.req_signed_op;
  end

  assign req_if.req_ready = !fifo_full;

  alu_drv_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_if.req_valid),
    .pop_i       (pop),
    .wdata_i     (push_data),
    .rdata_o     (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_o (fifo_empty_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && mon_ready && !fifo_empty) begin
          pop        = 1'b1;
          state_d    = APPLY;
          wait_cnt_d = CNT_W'(DUT_LATENCY);
        end
      end
      APPLY: begin
        state_d = (wait_cnt_q == '0) ? IDLE : WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (wait_cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The strobe fires in the cycle the counter reaches zero:
  // APPLY itself for a combinational DUT, otherwise the last WAIT cycle.
  always_comb begin
    strobe    = ((state_q == APPLY) && (wait_cnt_q == '0)) ||
                ((state_q == WAIT)  && (wait_cnt_q == CNT_W'(1)));
    operand_a = WIDTH'(op_q.operand_a);
    operand_b = WIDTH'(op_q.operand_b);
    opcode    = op_q.opcode;
    signed_op = op_q.signed_op;
`ifdef ALU_DRV_HOLD_ZERO_EN
    if (state_q == IDLE) begin
      operand_a = '0;
      operand_b = '0;
      opcode    = opcode_e'('0);
      signed_op = 1'b0;
    end
`endif
  end

  assign transaction_valid = strobe;
  assign busy              = busy_q;
  assign issued_count      = issued_count_q;

  // Datapath registers: applied transaction, completion count, busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= '0;
      issued_count_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      if (pop) begin
        op_q <= head_data;
      end
      if (strobe) begin
        issued_count_q <= issued_count_q + 32'd1;
      end
      busy_q <= (state_d != IDLE) || !fifo_empty_nxt;
    end
  end

endmodule

// File: tb/tb_alu_stim_driver.sv
module tb_alu_stim_driver;
  import alu_pkg::*;
  import alu_tb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_stim_driver_if #(.WIDTH(32)) req_if1();
  alu_stim_driver_if #(.WIDTH(32)) req_if0();

  logic        en1 = 1'b0, mr1 = 1'b0, en0 = 1'b0, mr0 = 1'b0;
  logic [31:0] a1, b1, a0, b0, cnt1, cnt0;
  opcode_e     oc1, oc0;
  logic        sg1, sg0, tv1, tv0, busy1, busy0;

  alu_stim_driver #(.WIDTH(32), .DEPTH(8), .DUT_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_if(req_if1), .enable(en1), .mon_ready(mr1),
    .operand_a(a1), .operand_b(b1), .opcode(oc1), .signed_op(sg1),
    .transaction_valid(tv1), .busy(busy1), .issued_count(cnt1)
  );

  alu_stim_driver #(.WIDTH(32), .DEPTH(8), .DUT_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_if(req_if0), .enable(en0), .mon_ready(mr0),
    .operand_a(a0), .operand_b(b0), .opcode(oc0), .signed_op(sg0),
    .transaction_valid(tv0), .busy(busy0), .issued_count(cnt0)
  );

  int          checks = 0, errors = 0;
  int          cyc = 0, strobes = 0, last_cyc = -1, n_acc = 0;
  bit          strict_gap = 1'b0;
  logic [31:0] model_cnt = '0;
  drv_req_t    exp_q[$];
  int          s0_cyc[$];
  logic [31:0] s0_a[$];

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  function automatic drv_req_t mk(input logic [31:0] a, input logic [31:0] b,
                                  input opcode_e op, input logic s);
    drv_req_t r;
    r.operand_a = a;
    r.operand_b = b;
    r.opcode    = op;
    r.signed_op = s;
    return r;
  endfunction

  function automatic drv_req_t rnd_req();
    return mk($urandom, $urandom, opcode_e'(4'($urandom_range(0, 9))), 1'($urandom_range(0, 1)));
  endfunction

  task automatic drive1(input drv_req_t r);
    req_if1.req_operand_a = r.operand_a;
    req_if1.req_operand_b = r.operand_b;
    req_if1.req_opcode    = r.opcode;
    req_if1.req_signed_op = r.signed_op;
  endtask

  task automatic drive0(input drv_req_t r);
    req_if0.req_operand_a = r.operand_a;
    req_if0.req_operand_b = r.operand_b;
    req_if0.req_opcode    = r.opcode;
    req_if0.req_signed_op = r.signed_op;
  endtask

  // Offer one request to the main driver and hold it until accepted.
  task automatic push1(input drv_req_t r);
    int t = 0;
    drive1(r);
    req_if1.req_valid = 1'b1;
    while (!req_if1.req_ready && t < 50) begin
      step(1);
      t++;
    end
    if (t >= 50) check_eq("push_timeout", 0, 1);
    step(1);
    req_if1.req_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int t = 0;
    while (strobes < target && t < budget) begin
      step(1);
      t++;
    end
    check_eq("strobe_wait", 96'(strobes >= target), 1);
  endtask

  always @(posedge clk) cyc++;

  // Requests accepted by the main driver, in order.
  always @(negedge clk) begin
    if (rst_n && req_if1.req_valid && req_if1.req_ready) begin
      exp_q.push_back(mk(req_if1.req_operand_a, req_if1.req_operand_b,
                         req_if1.req_opcode, req_if1.req_signed_op));
      n_acc++;
    end
  end

  // Each strobe must carry the oldest accepted request and the running count.
  always begin : mon1
    drv_req_t e;
    @(posedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = '0;
    end else if (tv1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("strobe_data", {a1, b1, oc1, sg1}, e);
      end
      check_eq("strobe_count", cnt1, model_cnt);
      model_cnt++;
      if (strict_gap && last_cyc >= 0) check_eq("strobe_gap", cyc - last_cyc, 3);
      last_cyc = cyc;
      strobes++;
    end
  end

  always begin : mon0
    @(posedge clk);
    #2;
    if (rst_n && tv0) begin
      s0_cyc.push_back(cyc);
      s0_a.push_back(a0);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    drv_req_t r;
    int sb, t, acc_base;
    logic [31:0] hold_a;
    req_if1.req_valid = 1'b0;
    req_if0.req_valid = 1'b0;
    drive1('0);
    drive0('0);

    // Reset values
    step(2);
    check_eq("rst_req_ready", req_if1.req_ready, 1);
    check_eq("rst_tv", tv1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_count", cnt1, 0);
    check_eq("rst_opa", a1, 0);
    check_eq("rst_opb", b1, 0);
    check_eq("rst_opcode", oc1, 0);
    check_eq("rst_signed", sg1, 0);
    rst_n = 1'b1;
    step(1);

    // Single request: operands one cycle after pop, strobe two cycles after.
    en1 = 1'b1;
    mr1 = 1'b1;
    drive1(mk(32'd5, 32'd3, OP_ADD, 1'b0));
    req_if1.req_valid = 1'b1;
    step(1);
    req_if1.req_valid = 1'b0;
    check_eq("t1_pop_tv", tv1, 0);
    check_eq("t1_pop_busy", busy1, 1);
    step(1);
    check_eq("t1_apply_opa", a1, 5);
    check_eq("t1_apply_opb", b1, 3);
    check_eq("t1_apply_tv", tv1, 0);
    step(1);
    check_eq("t1_strobe", tv1, 1);
    check_eq("t1_strobe_opa", a1, 5);
    step(1);
    check_eq("t1_after_tv", tv1, 0);
    check_eq("t1_count", cnt1, 1);
    check_eq("t1_busy_drop", busy1, 0);
`ifdef ALU_DRV_HOLD_ZERO_EN
    check_eq("t1_idle_opa", a1, 0);
`else
    check_eq("t1_idle_opa", a1, 5);
`endif

    // Fill to full with enable low, then drain back-to-back.
    en1 = 1'b0;
    for (int i = 0; i < 8; i++) push1(rnd_req());
    check_eq("t2_full_ready", req_if1.req_ready, 0);
    check_eq("t2_full_busy", busy1, 1);
    drive1(rnd_req());
    req_if1.req_valid = 1'b1;
    sb = strobes;
    step(3);
    req_if1.req_valid = 1'b0;
    check_eq("t2_no_strobe", strobes, sb);
    last_cyc = -1;
    strict_gap = 1'b1;
    en1 = 1'b1;
    wait_strobes(sb + 8, 60);
    strict_gap = 1'b0;
    step(1);
    check_eq("t2_busy_drop", busy1, 0);
    check_eq("t2_ready_back", req_if1.req_ready, 1);
    check_eq("t2_count", cnt1, 9);

    // Monitor back-pressure, and a drop during WAIT keeps the strobe.
    mr1 = 1'b0;
    push1(rnd_req());
    push1(rnd_req());
    sb = strobes;
    step(5);
    check_eq("t3_stalled", strobes, sb);
    check_eq("t3_stalled_busy", busy1, 1);
    mr1 = 1'b1;
    step(1);
    mr1 = 1'b0;
    check_eq("t3_apply_tv", tv1, 0);
    step(1);
    check_eq("t3_pending_strobe", tv1, 1);
    step(5);
    check_eq("t3_held_second", strobes, sb + 1);
    mr1 = 1'b1;
    wait_strobes(sb + 2, 20);
    step(2);

    // Combinational DUT: strobe coincides with operands, 2-cycle spacing.
    en0 = 1'b1;
    mr0 = 1'b1;
    drive0(mk(32'h11, 32'h22, OP_XOR, 1'b1));
    req_if0.req_valid = 1'b1;
    step(1);
    check_eq("t4_pop_tv", tv0, 0);
    check_eq("t4_pop_opa", a0, 0);
    drive0(mk(32'h100, 32'h0, OP_SUB, 1'b0));
    step(1);
    check_eq("t4_strobe", tv0, 1);
    check_eq("t4_strobe_opa", a0, 32'h11);
    check_eq("t4_strobe_opb", b0, 32'h22);
    check_eq("t4_strobe_opc", oc0, OP_XOR);
    check_eq("t4_strobe_sgn", sg0, 1);
    for (int i = 1; i < 3; i++) begin
      drive0(mk(32'h100 + 32'(i), 32'h0, OP_SUB, 1'b0));
      step(1);
    end
    req_if0.req_valid = 1'b0;
    t = 0;
    while (s0_cyc.size() < 4 && t < 20) begin
      step(1);
      t++;
    end
    check_eq("t4_strobe_total", s0_cyc.size(), 4);
    if (s0_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        check_eq("t4_gap", s0_cyc[i] - s0_cyc[i-1], 2);
        check_eq("t4_order", s0_a[i], 32'h100 + 32'(i - 1));
      end
    end
    step(1);
    check_eq("t4_count", cnt0, 4);
    check_eq("t4_busy", busy0, 0);

    // Reset during WAIT with requests queued.
    en1 = 1'b0;
    push1(mk(32'hA1, 32'hB1, OP_AND, 1'b0));
    push1(rnd_req());
    push1(rnd_req());
    push1(rnd_req());
    en1 = 1'b1;
    step(1);
    check_eq("t5_apply_opa", a1, 32'hA1);
    sb = strobes;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_eq("t5_rst_tv", tv1, 0);
    check_eq("t5_rst_opa", a1, 0);
    check_eq("t5_rst_opb", b1, 0);
    check_eq("t5_rst_opc", oc1, 0);
    check_eq("t5_rst_sgn", sg1, 0);
    check_eq("t5_rst_busy", busy1, 0);
    check_eq("t5_rst_ready", req_if1.req_ready, 1);
    check_eq("t5_rst_count", cnt1, 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    check_eq("t5_no_strobe", strobes, sb);
    check_eq("t5_idle_busy", busy1, 0);

    // Counter wrap from a preloaded all-ones value.
    @(negedge clk);
    force dut.issued_count_q = 32'hFFFF_FFFF;
    #1 release dut.issued_count_q;
    model_cnt = 32'hFFFF_FFFF;
    step(1);
    check_eq("t6_preload", cnt1, 32'hFFFF_FFFF);
    sb = strobes;
    push1(rnd_req());
    push1(rnd_req());
    wait_strobes(sb + 1, 20);
    step(1);
    check_eq("t6_wrap0", cnt1, 32'h0);
    wait_strobes(sb + 2, 20);
    step(1);
    check_eq("t6_wrap1", cnt1, 32'h1);

    // Random traffic with random enable / monitor back-pressure.
    acc_base = n_acc;
    for (int i = 0; i < 400; i++) begin
      en1 = ($urandom_range(0, 3) != 0);
      mr1 = ($urandom_range(0, 3) != 0);
      r = rnd_req();
      drive1(r);
      req_if1.req_valid = 1'($urandom_range(0, 1));
      step(1);
    end
    req_if1.req_valid = 1'b0;
    en1 = 1'b1;
    mr1 = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || busy1) && t < 300) begin
      step(1);
      t++;
    end
    check_eq("t7_drained", exp_q.size(), 0);
    step(1);
    check_eq("t7_busy", busy1, 0);
    check_eq("t7_count", cnt1, 32'd1 + 32'(n_acc - acc_base));
    hold_a = a1;
    step(3);
    check_eq("t7_idle_hold", a1, hold_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_stim_driver.md
# alu_stim_driver

Synthesizable stimulus driver on the input side of the ALU bench, the counterpart of the ALU monitor. It accepts operand/opcode requests from a generator over a valid/ready handshake, buffers them in a small FIFO, and presents one transaction at a time to the DUT inputs. After the DUT's fixed latency it pulses `transaction_valid` so the monitor samples inputs and outputs together.

## Interface
Parameters:
- `WIDTH`, 32, operand width
- `DEPTH`, 8, request FIFO entries; power of two, ≥2
- `DUT_LATENCY`, 1, cycles from operands applied to DUT result valid; 0 means a combinational ALU

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  generator offers a request
- `req_ready`  out  1  FIFO can accept; equals not-full
- `req_operand_a`  in  WIDTH  request operand A
- `req_operand_b`  in  WIDTH  request operand B
- `req_opcode`  in  `opcode_e`  request opcode
- `req_signed_op`  in  1  request signedness
- `enable`  in  1  permits issuing new transactions
- `mon_ready`  in  1  monitor can accept a transaction
- `operand_a`  out  WIDTH  to DUT
- `operand_b`  out  WIDTH  to DUT
- `opcode`  out  `opcode_e`  to DUT
- `signed_op`  out  1  to DUT
- `transaction_valid`  out  1  one-cycle strobe to monitor; DUT result valid
- `busy`  out  1  high when FIFO non-empty or FSM not IDLE
- `issued_count`  out  32  completed transactions, wraps at 2^32

## Operation
- Push: `req_valid && req_ready` writes one entry. A push into a full FIFO cannot occur because `req_ready` is 0.
- FSM states: IDLE, APPLY, WAIT.
  - IDLE → APPLY: requires `enable && mon_ready && !empty`. On the transition, pop the head into the output registers and load `wait_cnt = DUT_LATENCY`.
  - APPLY: operands are visible on the outputs. If `wait_cnt == 0`, assert `transaction_valid`, increment `issued_count`, then go to IDLE. Otherwise go to WAIT.
  - WAIT: decrement `wait_cnt`. When it reaches 0, assert `transaction_valid`, increment the count, and go to IDLE.
- Operand outputs stay stable from APPLY through the strobe cycle inclusive.
- `enable` or `mon_ready` falling mid-transaction does not abort it. They are checked only at IDLE.
- A simultaneous push and pop is legal at any non-full occupancy. Occupancy is unchanged.
- Reset (asynchronous, any time):
  - FIFO emptied, FSM to IDLE, any in-flight transaction discarded with no strobe.
  - Outputs: `req_ready=1`, `operand_a/b=0`, `opcode='0`, `signed_op=0`, `transaction_valid=0`, `busy=0`, `issued_count=0`.

## Timing
- Pop in cycle N. Operands are visible from N+1 (APPLY). The strobe occurs in cycle N+1+`DUT_LATENCY`.
- Throughput is one transaction per `DUT_LATENCY+2` cycles. IDLE always takes at least one cycle between transactions.
- `req_ready` comes combinationally from registered occupancy and has no dependency on `req_valid`.
- `busy` and `issued_count` are registered.
- The pointers are log2(`DEPTH`)+1 bits. Full when the MSBs differ and the low bits are equal; empty when all bits are equal. Pointers wrap naturally.

## Configuration
- `ALU_DRV_HOLD_ZERO_EN`
  - Defined: in IDLE, `operand_a`, `operand_b`, `opcode` and `signed_op` are driven to 0, so DUT inputs are quiet between transactions.
  - Undefined: the outputs hold the last applied transaction's values until the next pop.

## Structure
- `alu_tb_pkg` holds the `drv_state_e` enum (IDLE, APPLY, WAIT) and a packed `drv_req_t` struct {operand_a, operand_b, opcode, signed_op}, parameterized by WIDTH through the package's existing width constant.
- `opcode_e` is taken from `alu_pkg`.
- One sub-module, `alu_drv_fifo`: a synchronous FIFO of `drv_req_t` with push/pop/full/empty.
- FSM, output registers and counter live in `alu_stim_driver`.

## Test plan
- Single request, A=5, B=3, `DUT_LATENCY=1`, `enable=1`, `mon_ready=1` → operands appear 1 cycle after pop, `transaction_valid` pulses exactly one cycle 2 cycles after pop, `issued_count=1`.
- Push 8 requests with `enable=0`, `DEPTH=8` → `req_ready=0` after the 8th. Raise `enable` → 8 strobes at 3-cycle spacing, in push order, and `busy` drops after the last.
- `mon_ready=0` with 2 queued → no pop, no strobe. Raise it → issue resumes. Dropping it during WAIT does not suppress the pending strobe.
- `DUT_LATENCY=0` → the strobe coincides with the first cycle operands are visible. Spacing is 2 cycles.
- `rst_n` asserted during WAIT with 3 queued → no strobe, all outputs at reset values, `req_ready=1`, `issued_count=0`.
- Preload `issued_count` near 0xFFFFFFFF (force), then complete 2 transactions → count wraps to 0x00000000 and then 0x00000001.
